// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: in-order writeback FIFO in front of the GPR file's single
// write port. Accepts up to two results per cycle (ALU first, then load),
// drains one per cycle, and offers a busy/forward lookup for two source IDs.
module gpr_wb_queue #(
    parameter int GPR_BITS    = 32,
    parameter int GPR_ID_BITS = 5,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alu_valid,
    output logic                   alu_ready,
    input  logic [GPR_ID_BITS-1:0] alu_id,
    input  logic [GPR_BITS-1:0]    alu_val,
    input  logic                   mem_valid,
    output logic                   mem_ready,
    input  logic [GPR_ID_BITS-1:0] mem_id,
    input  logic [GPR_BITS-1:0]    mem_val,
    output logic                   gpr_we,
    output logic [GPR_ID_BITS-1:0] gpr_write_id,
    output logic [GPR_BITS-1:0]    gpr_write_val,
    input  logic [GPR_ID_BITS-1:0] rd1_id,
    input  logic [GPR_ID_BITS-1:0] rd2_id,
    output logic                   rd1_busy,
    output logic                   rd2_busy,
    output logic [GPR_BITS-1:0]    rd1_fwd,
    output logic [GPR_BITS-1:0]    rd2_fwd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [GPR_ID_BITS-1:0] id;
        logic [GPR_BITS-1:0]    val;
    } entry_t;

    entry_t         entries [DEPTH];
    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [CW-1:0]  count;

    logic           pop;
    logic           alu_push;
    logic           mem_push;
    logic [CW:0]    free;
    logic [CW:0]    mem_need;
    logic [PW-1:0]  mem_slot;

    // The head entry is presented to the GPR file whenever the queue is non-empty.
    assign gpr_we = (count != '0);
    assign pop    = gpr_we;

    // Slots available this cycle count the one freed by the concurrent pop.
    assign free     = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(gpr_we);
    assign mem_need = (CW+1)'(1) + (CW+1)'(alu_valid && (alu_id != '0));

    // x0 results are acknowledged unconditionally since they are never stored.
    assign alu_ready = (free >= (CW+1)'(1)) || (alu_id == '0);
    assign mem_ready = (free >= mem_need)   || (mem_id == '0);

    assign alu_push = alu_valid && alu_ready && (alu_id != '0);
    assign mem_push = mem_valid && mem_ready && (mem_id != '0);

    // The load entry lands behind the ALU entry when both push in one cycle.
    assign mem_slot = tail + PW'(alu_push);

    // Drive the GPR write port from the head entry, zero when empty.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        gpr_write_id  = '0;
        gpr_write_val = '0;
        if (gpr_we) begin
            gpr_write_id  = entries[head].id;
            gpr_write_val = entries[head].val;
        end
    end

    // Scan stored entries oldest to youngest; the last hit is the youngest.
    always_comb begin
        logic [PW-1:0] idx;
        rd1_busy = 1'b0;
        rd2_busy = 1'b0;
        rd1_fwd  = '0;
        rd2_fwd  = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < count) begin
                idx = head + PW'(i);
                if ((rd1_id != '0) && (entries[idx].id == rd1_id)) begin
                    rd1_busy = 1'b1;
                    rd1_fwd  = entries[idx].val;
                end
                if ((rd2_id != '0) && (entries[idx].id == rd2_id)) begin
                    rd2_busy = 1'b1;
                    rd2_fwd  = entries[idx].val;
                end
            end
        end
    end

    // Queue storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            // NOTE: the entry array is small and reset to zero so stale values
            // never appear on the forward paths after reset.
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates keep every register sampling pre-edge values.
            if (alu_push) begin
                entries[tail] <= '{id: alu_id, val: alu_val};
            end
            if (mem_push) begin
                entries[mem_slot] <= '{id: mem_id, val: mem_val};
            end
            head  <= head + PW'(pop);
            tail  <= tail + PW'(alu_push) + PW'(mem_push);
            count <= count + CW'(alu_push) + CW'(mem_push) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_gpr_wb_queue.sv
// tb_gpr_wb_queue: directed scenarios followed by random traffic, every cycle
// compared against a queue-based reference model of the writeback buffer.
module tb_gpr_wb_queue;

    localparam int GPR_BITS    = 32;
    localparam int GPR_ID_BITS = 5;
    localparam int DEPTH       = 4;

    typedef struct {
        logic [GPR_ID_BITS-1:0] id;
        logic [GPR_BITS-1:0]    val;
    } item_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   alu_valid = 1'b0;
    logic                   alu_ready;
    logic [GPR_ID_BITS-1:0] alu_id = '0;
    logic [GPR_BITS-1:0]    alu_val = '0;
    logic                   mem_valid = 1'b0;
    logic                   mem_ready;
    logic [GPR_ID_BITS-1:0] mem_id = '0;
    logic [GPR_BITS-1:0]    mem_val = '0;
    logic                   gpr_we;
    logic [GPR_ID_BITS-1:0] gpr_write_id;
    logic [GPR_BITS-1:0]    gpr_write_val;
    logic [GPR_ID_BITS-1:0] rd1_id = '0;
    logic [GPR_ID_BITS-1:0] rd2_id = '0;
    logic                   rd1_busy;
    logic                   rd2_busy;
    logic [GPR_BITS-1:0]    rd1_fwd;
    logic [GPR_BITS-1:0]    rd2_fwd;

    int checks   = 0;
    int failures = 0;

    item_t model_q [$];

    gpr_wb_queue #(
        .GPR_BITS   (GPR_BITS),
        .GPR_ID_BITS(GPR_ID_BITS),
        .DEPTH      (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .alu_valid    (alu_valid),
        .alu_ready    (alu_ready),
        .alu_id       (alu_id),
        .alu_val      (alu_val),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_id       (mem_id),
        .mem_val      (mem_val),
        .gpr_we       (gpr_we),
        .gpr_write_id (gpr_write_id),
        .gpr_write_val(gpr_write_val),
        .rd1_id       (rd1_id),
        .rd2_id       (rd2_id),
        .rd1_busy     (rd1_busy),
        .rd2_busy     (rd2_busy),
        .rd1_fwd      (rd1_fwd),
        .rd2_fwd      (rd2_fwd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: free slots include the one released by this cycle's drain.
    function automatic int model_free();
        return DEPTH - model_q.size() + ((model_q.size() != 0) ? 1 : 0);
    endfunction

    function automatic logic model_alu_ready();
        return (model_free() >= 1) || (alu_id == 0);
    endfunction

    function automatic logic model_mem_ready();
        int need;
        need = 1 + ((alu_valid && alu_id != 0) ? 1 : 0);
        return (model_free() >= need) || (mem_id == 0);
    endfunction

    task automatic model_lookup(input logic [GPR_ID_BITS-1:0] rid,
                                output logic busy, output logic [GPR_BITS-1:0] fwd);
        busy = 1'b0;
        fwd  = '0;
        if (rid != 0) begin
            foreach (model_q[i]) begin
                if (model_q[i].id == rid) begin
                    busy = 1'b1;
                    fwd  = model_q[i].val;
                end
            end
        end
    endtask

    // Compare every DUT output against the model for the current inputs.
    task automatic compare_all();
        logic                b;
        logic [GPR_BITS-1:0] f;
        logic                we_exp;
        we_exp = (model_q.size() != 0);
        check("gpr_we", 32'(gpr_we), 32'(we_exp));
        check("gpr_write_id", 32'(gpr_write_id), we_exp ? 32'(model_q[0].id) : 32'd0);
        check("gpr_write_val", gpr_write_val, we_exp ? model_q[0].val : 32'd0);
        check("alu_ready", 32'(alu_ready), 32'(model_alu_ready()));
        check("mem_ready", 32'(mem_ready), 32'(model_mem_ready()));
        model_lookup(rd1_id, b, f);
        check("rd1_busy", 32'(rd1_busy), 32'(b));
        check("rd1_fwd", rd1_fwd, f);
        model_lookup(rd2_id, b, f);
        check("rd2_busy", 32'(rd2_busy), 32'(b));
        check("rd2_fwd", rd2_fwd, f);
    endtask

    task automatic drive(input logic av, input logic [GPR_ID_BITS-1:0] ai, input logic [GPR_BITS-1:0] avl,
                         input logic mv, input logic [GPR_ID_BITS-1:0] mi, input logic [GPR_BITS-1:0] mvl,
                         input logic [GPR_ID_BITS-1:0] r1, input logic [GPR_ID_BITS-1:0] r2);
        alu_valid = av;
        alu_id    = ai;
        alu_val   = avl;
        mem_valid = mv;
        mem_id    = mi;
        mem_val   = mvl;
        rd1_id    = r1;
        rd2_id    = r2;
    endtask

    // Check outputs, clock once, then advance the model with what was accepted.
    task automatic cycle();
        logic acc_alu;
        logic acc_mem;
        #1;
        compare_all();
        acc_alu = alu_valid && model_alu_ready() && (alu_id != 0);
        acc_mem = mem_valid && model_mem_ready() && (mem_id != 0);
        @(posedge clk);
        if (model_q.size() != 0) void'(model_q.pop_front());
        if (acc_alu) model_q.push_back('{id: alu_id, val: alu_val});
        if (acc_mem) model_q.push_back('{id: mem_id, val: mem_val});
        #1;
    endtask

    task automatic step(input logic av, input logic [GPR_ID_BITS-1:0] ai, input logic [GPR_BITS-1:0] avl,
                        input logic mv, input logic [GPR_ID_BITS-1:0] mi, input logic [GPR_BITS-1:0] mvl,
                        input logic [GPR_ID_BITS-1:0] r1, input logic [GPR_ID_BITS-1:0] r2);
        drive(av, ai, avl, mv, mi, mvl, r1, r2);
        cycle();
    endtask

    task automatic idle(input logic [GPR_ID_BITS-1:0] r1, input logic [GPR_ID_BITS-1:0] r2);
        step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        #12;
        check("rst_gpr_we", 32'(gpr_we), 32'd0);
        check("rst_alu_ready", 32'(alu_ready), 32'd1);
        check("rst_mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(5'd0, 5'd0);

        // Single ALU push, then drain
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        check("lat_we", 32'(gpr_we), 32'd1);
        check("lat_id", 32'(gpr_write_id), 32'd5);
        check("lat_val", gpr_write_val, 32'hDEADBEEF);
        idle(5'd5, 5'd0);
        check("lat_we_after", 32'(gpr_we), 32'd0);

        // Dual push on empty queue drains in ALU-then-mem order
        drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 5'd3, 5'd4);
        #1;
        check("dual_alu_ready", 32'(alu_ready), 32'd1);
        check("dual_mem_ready", 32'(mem_ready), 32'd1);
        cycle();
        check("dual_first_id", 32'(gpr_write_id), 32'd3);
        idle(5'd3, 5'd4);
        check("dual_second_id", 32'(gpr_write_id), 32'd4);
        idle(5'd0, 5'd0);
        check("dual_empty", 32'(gpr_we), 32'd0);

        // Fill to DEPTH, then contention at full
        step(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 5'd1, 5'd2);
        step(1'b1, 5'd6, 32'h66, 1'b1, 5'd8, 32'h88, 5'd6, 5'd8);
        step(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd9, 5'd10);
        drive(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 5'd11, 5'd12);
        #1;
        check("full_alu_ready", 32'(alu_ready), 32'd1);
        check("full_mem_ready", 32'(mem_ready), 32'd0);
        cycle();
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hCC, 5'd12, 5'd11);
        #1;
        check("retry_mem_ready", 32'(mem_ready), 32'd1);
        cycle();
        for (int i = 0; i < DEPTH + 1; i++) idle(5'd12, 5'd11);
        check("fill_drained", 32'(gpr_we), 32'd0);

        // Duplicate IDs: youngest value forwards
        step(1'b1, 5'd7, 32'd10, 1'b1, 5'd7, 32'd20, 5'd7, 5'd7);
        rd1_id = 5'd7;
        #1;
        check("dup_busy", 32'(rd1_busy), 32'd1);
        check("dup_fwd", rd1_fwd, 32'd20);
        idle(5'd7, 5'd0);
        idle(5'd7, 5'd0);
        #1;
        check("dup_busy_after", 32'(rd1_busy), 32'd0);
        check("dup_fwd_after", rd1_fwd, 32'd0);

        // x0 writes are acknowledged but never stored
        drive(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        check("x0_alu_ready", 32'(alu_ready), 32'd1);
        cycle();
        check("x0_no_we", 32'(gpr_we), 32'd0);
        check("x0_rd2_busy", 32'(rd2_busy), 32'd0);

        // Mid-cycle reset with three entries queued
        step(1'b1, 5'd13, 32'h13, 1'b1, 5'd14, 32'h14, 5'd13, 5'd14);
        step(1'b1, 5'd15, 32'h15, 1'b1, 5'd16, 32'h16, 5'd15, 5'd16);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd15, 5'd16);
        #1;
        check("pre_rst_we", 32'(gpr_we), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        model_q.delete();
        check("mid_rst_we", 32'(gpr_we), 32'd0);
        check("mid_rst_id", 32'(gpr_write_id), 32'd0);
        check("mid_rst_val", gpr_write_val, 32'd0);
        check("mid_rst_busy1", 32'(rd1_busy), 32'd0);
        check("mid_rst_fwd2", rd2_fwd, 32'd0);
        check("mid_rst_alu_ready", 32'(alu_ready), 32'd1);
        check("mid_rst_mem_ready", 32'(mem_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            idle(5'd15, 5'd16);
            check("post_rst_we", 32'(gpr_we), 32'd0);
        end

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(5'd0, 5'd0);
        check("final_empty", 32'(gpr_we), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
